// File: rtl/addsub_serial_if.sv
// Handshake and data bundle for the chunk-serial adder/subtractor.
// The master drives requests and takes results; the slave is the arithmetic unit.
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb;
  logic             ovf;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, cb, ovf, zero, acc
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, cb, ovf, zero, acc
  );
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor with an accumulator. The operation is processed
// CHUNK bits per cycle from the LSB upward, so only a CHUNK-bit carry chain is needed.
// Flags (unsigned carry/borrow, signed overflow, zero) and optional unsigned
// saturation are resolved as the last chunk completes.
module addsub_serial #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int N   = WIDTH / CHUNK;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q, result_q, acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             out_valid_q, cb_q, ovf_q, zero_q;

  int unsigned      lsb;
  logic [CHUNK:0]   chunk_d;
  logic [WIDTH-1:0] sum_d, final_d;
  logic             cb_d, ovf_d;

  // Current chunk sum plus the full-width result and flags it would complete.
  always_comb begin
    lsb     = int'(cnt_q) * CHUNK;
    chunk_d = {1'b0, x_q[lsb +: CHUNK]} + {1'b0, y_q[lsb +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
    sum_d   = sum_q;
    sum_d[lsb +: CHUNK] = chunk_d[CHUNK-1:0];
    // Subtract inverts the raw carry so cb reads as a borrow.
    cb_d    = op_q[0] ^ chunk_d[CHUNK];
    ovf_d   = (x_q[MSB] == y_q[MSB]) && (sum_d[MSB] != x_q[MSB]);
    final_d = sum_d;
    if ((SATURATE != 0) && cb_d) begin
      final_d = op_q[0] ? '0 : '1;
    end
  end

  // Control FSM, operand capture, chunk accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      out_valid_q <= 1'b0;
      cb_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.acc_clr) begin
            acc_q <= '0;
          end
          if (bus.in_valid) begin
            op_q    <= bus.op;
            // A clear in the accept cycle applies before the accumulator is read.
            x_q     <= bus.op[1] ? (bus.acc_clr ? '0 : acc_q) : bus.a;
            y_q     <= bus.op[0] ? ~bus.b : bus.b;
            carry_q <= bus.op[0];
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= sum_d;
          carry_q <= chunk_d[CHUNK];
          if (cnt_q == CW'(N - 1)) begin
            state_q     <= DONE;
            result_q    <= final_d;
            cb_q        <= cb_d;
            ovf_q       <= ovf_d;
            zero_q      <= (final_d == '0);
            out_valid_q <= 1'b1;
            if (op_q[1]) begin
              acc_q <= final_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cb        = cb_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: a plain instance and a saturating instance
// receive identical stimulus; expected values are hand-computed constants.
module tb_addsub_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] r_res, r_acc, s_res;
  logic        r_cb, r_ovf, r_zero, s_cb, s_zero;
  int          cyc;

  addsub_serial_if #(.WIDTH(16)) bus ();
  addsub_serial_if #(.WIDTH(16)) sbus ();

  addsub_serial #(.WIDTH(16), .CHUNK(4), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  addsub_serial #(.WIDTH(16), .CHUNK(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic vld, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic clr);
    bus.in_valid = vld;  bus.op = op;  bus.a = a;  bus.b = b;  bus.acc_clr = clr;
    sbus.in_valid = vld; sbus.op = op; sbus.a = a; sbus.b = b; sbus.acc_clr = clr;
  endtask

  task automatic set_out_ready(input logic v);
    bus.out_ready  = v;
    sbus.out_ready = v;
  endtask

  // Issue one operation from IDLE, wait for the result, capture it, then handshake.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic clr);
    drive(1'b1, op, a, b, clr);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, cyc);
    end
    r_res = bus.result;  r_cb = bus.cb;  r_ovf = bus.ovf;  r_zero = bus.zero;  r_acc = bus.acc;
    s_res = sbus.result; s_cb = sbus.cb; s_zero = sbus.zero;
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    set_out_ready(1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b, required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", bus.out_valid); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL rst_result: got %h, required 0000", bus.result); end
    checks++; if ({bus.cb, bus.ovf, bus.zero} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b, required 000", {bus.cb, bus.ovf, bus.zero}); end
    checks++; if (bus.acc !== 16'h0) begin errors++; $display("FAIL rst_acc: got %h, required 0000", bus.acc); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    do_op(2'b00, 16'h00FF, 16'h0001, 1'b0);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL add_latency: got %0d, required 4", cyc); end
    checks++; if (r_res !== 16'h0100) begin errors++; $display("FAIL add_result: got %h, required 0100", r_res); end
    checks++; if ({r_cb, r_ovf, r_zero} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b, required 000", {r_cb, r_ovf, r_zero}); end
    do_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    checks++; if (r_res !== 16'h8000) begin errors++; $display("FAIL ovf_result: got %h, required 8000", r_res); end
    checks++; if ({r_cb, r_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags: got cb,ovf=%b, required 01", {r_cb, r_ovf}); end
    do_op(2'b00, 16'hFFFF, 16'h0002, 1'b0);
    checks++; if (r_res !== 16'h0001 || r_cb !== 1'b1) begin errors++; $display("FAIL carry_raw: got %h cb=%0b, required 0001 cb=1", r_res, r_cb); end
    checks++; if (s_res !== 16'hFFFF || s_cb !== 1'b1) begin errors++; $display("FAIL sat_add: got %h cb=%0b, required ffff cb=1", s_res, s_cb); end
  endtask

  task automatic test_sub;
    do_op(2'b01, 16'h0003, 16'h0005, 1'b0);
    checks++; if (r_res !== 16'hFFFE) begin errors++; $display("FAIL borrow_result: got %h, required fffe", r_res); end
    checks++; if ({r_cb, r_ovf} !== 2'b10) begin errors++; $display("FAIL borrow_flags: got cb,ovf=%b, required 10", {r_cb, r_ovf}); end
    do_op(2'b01, 16'h1234, 16'h1234, 1'b0);
    checks++; if (r_res !== 16'h0000 || r_zero !== 1'b1 || r_cb !== 1'b0) begin errors++; $display("FAIL sub_zero: got %h zero=%0b cb=%0b, required 0000 zero=1 cb=0", r_res, r_zero, r_cb); end
    do_op(2'b01, 16'h0001, 16'h0002, 1'b0);
    checks++; if (r_res !== 16'hFFFF) begin errors++; $display("FAIL sub_raw: got %h, required ffff", r_res); end
    checks++; if (s_res !== 16'h0000 || s_cb !== 1'b1 || s_zero !== 1'b1) begin errors++; $display("FAIL sat_sub: got %h cb=%0b zero=%0b, required 0000 cb=1 zero=1", s_res, s_cb, s_zero); end
  endtask

  task automatic test_acc;
    do_op(2'b00, 16'h0101, 16'h0202, 1'b0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    checks++; if (bus.acc !== 16'h0) begin errors++; $display("FAIL acc_clr: got %h, required 0000", bus.acc); end
    for (int i = 0; i < 3; i++) do_op(2'b10, 16'h0, 16'h0005, 1'b0);
    checks++; if (r_acc !== 16'h000F) begin errors++; $display("FAIL acc_add3: got %h, required 000f", r_acc); end
    do_op(2'b11, 16'h0, 16'h0010, 1'b0);
    checks++; if (r_acc !== 16'hFFFF || r_cb !== 1'b1) begin errors++; $display("FAIL acc_sub: got %h cb=%0b, required ffff cb=1", r_acc, r_cb); end
    do_op(2'b00, 16'h0001, 16'h0001, 1'b0);
    checks++; if (bus.acc !== 16'hFFFF) begin errors++; $display("FAIL acc_hold: got %h, required ffff", bus.acc); end
    do_op(2'b10, 16'h0, 16'h0007, 1'b1);
    checks++; if (r_acc !== 16'h0007 || r_res !== 16'h0007) begin errors++; $display("FAIL acc_clr_op: got acc=%h res=%h, required 0007", r_acc, r_res); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b00, 16'h0010, 16'h0020, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 16'h0001, 16'h0001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %0b, required 0", bus.in_ready); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 16'h0030 ||
          {bus.cb, bus.ovf, bus.zero} !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold: got ov=%0b ir=%0b res=%h flags=%b, required ov=1 ir=0 res=0030 flags=000",
                 bus.out_valid, bus.in_ready, bus.result, {bus.cb, bus.ovf, bus.zero});
      end
    end
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ov=%0b ir=%0b, required ov=0 ir=1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept2: got in_ready=%0b, required 0", bus.in_ready); end
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 4 || bus.result !== 16'h0002) begin errors++; $display("FAIL bp_second: got cyc=%0d res=%h, required cyc=4 res=0002", cyc, bus.result); end
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 2'b10, 16'h0, 16'h0001, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.acc !== 16'h0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got ov=%0b acc=%h ir=%0b, required ov=0 acc=0000 ir=1", bus.out_valid, bus.acc, bus.in_ready); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b00, 16'h1111, 16'h2222, 1'b0);
    checks++; if (r_res !== 16'h3333 || cyc !== 4) begin errors++; $display("FAIL after_reset: got res=%h cyc=%0d, required 3333 cyc=4", r_res, cyc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_add;
    test_sub;
    test_acc;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
